input_vc_ctrl: RTL and testbench
================================

# input_vc_ctrl

Input-port controller of the mesh router: one instance per input port (PE, S, N, E, W). It accepts 64-bit packets from the upstream link into two virtual-channel buffers (even/odd) and precomputes the XY route when each packet is written. It presents the packet whose VC matches the current polarity to the five output controllers as a one-hot request, with the hop field already updated. A buffer is freed when the granting output controller returns its clear.

## Interface

Parameters:
- DW, 64, packet width (bit layout below is fixed for DW=64)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- polarity  in  1  0 = even cycle, 1 = odd cycle; toggles every cycle, driven by the router top
- send_in  in  1  upstream link has a valid packet on data_in
- ready_in  out  1  this port can accept a packet this cycle
- data_in  in  64  packet from the link
- req  out  5  one-hot output request; [0]=PE, [1]=S, [2]=N, [3]=E, [4]=W (same order as the arbiter grant)
- data_out  out  64  head packet of the VC selected by polarity, with hop field updated
- clear  in  5  OR of the clear lines returned by the five output controllers for this port

## Operation

- Packet fields:
  - [63] vc
  - [62] x direction: 0 = E, 1 = W
  - [61] y direction: 0 = N, 1 = S
  - [60:56] reserved
  - [55:52] hop_x
  - [51:48] hop_y
  - [47:0] payload; passed through unchanged.
- State per VC v in {0,1}:
  - full[v]
  - hdr[v]: 64-bit stored packet, header already rewritten
  - route[v]: 5-bit one-hot route.
- Link side:
  - ready_in = ~full[~polarity].
  - On a clock edge where send_in & ready_in, write buf[~polarity] and set full[~polarity] to 1.
  - If data_in[63] != ~polarity, issue a $display error; the packet is still stored.
- Route computation, done at write time (XY routing):
  - hop_x != 0: route = E or W according to bit 62; stored hop_x = hop_x - 1.
  - Else hop_y != 0: route = N or S according to bit 61; stored hop_y = hop_y - 1.
  - Else: route = PE; header stored unchanged.
  - In the stored copy, bit 63 is forced to the buffer index.
- Router side, combinational from registers and polarity:
  - req = full[polarity] ? route[polarity] : 0.
  - data_out = full[polarity] ? hdr[polarity] : 0.
- Free:
  - On a clock edge where polarity = p, full[p] = 1 and clear != 0: set full[p] to 0.
  - Any set bit of clear frees the buffer. A clear that is not one-hot issues a $display error.
  - clear while full[p] = 0 is ignored.
- The write and free paths always target different VCs (~p and p), so both may occur on the same edge and are independent.
- The block never drops a packet. The sender holds data_in while ready_in is 0.

## Timing

- Reset (synchronous): full[1:0] = 0; hdr and route cleared to 0. Outputs after reset: ready_in = 1, req = 0, data_out = 0.
- A mid-operation reset discards both buffered packets, with no clear or request emitted.
- Latency: a packet written at an edge with polarity = 1 (into VC 0) drives req and data_out during the next cycle (polarity = 0).
  - That is one cycle from acceptance to request.
- req remains asserted on alternate cycles, every cycle with matching polarity, until cleared. Arbitration loss costs 2 cycles per retry.
- After a free at an edge with polarity = p, ready_in for VC p rises in the following cycle, because that cycle has polarity ~p.
- Throughput: one packet per VC per 2 cycles; one packet per port per cycle in steady state.
- req, data_out and ready_in are combinational from registers and polarity only. There is no path from clear or send_in to any output, which breaks the req→grant→clear loop.

## Test plan

- Reset, then idle:
  - Required: ready_in = 1, req = 5'b00000 and data_out = 0 for 10 cycles, in both polarities.
- XY decode. At polarity = 1, send 0x0_?_?_?: header bit62 = 0, hop_x = 2, hop_y = 3, payload 0xABCD.
  - Required next cycle: req = 5'b01000 (E) and data_out[55:48] = 8'h13.
  - Apply clear = 5'b01000: full[0] clears and VC 0 is accepted again at the next polarity = 1 cycle.
- Local delivery. Send hop_x = 0, hop_y = 0.
  - Required: req = 5'b00001 and data_out equal to the input except bit 63.
  - Apply clear = 5'b00001 and check the buffer frees.
- Backpressure. Fill both VCs and never assert clear.
  - Required: ready_in = 0 in every cycle; req alternates between the two stored routes each cycle; an asserted send_in is not written.
- Simultaneous events. In one cycle with polarity = 0, write VC 1 and clear VC 0.
  - Required: VC 0 is empty and VC 1 holds the new packet.
  - Also: clear with VC empty → no state change; clear = 5'b00110 → buffer freed and error printed.
- Reset mid-operation with both VCs full.
  - Required: the next cycle shows req = 0 and ready_in = 1; an old packet never reappears.

Source files
------------

// File: rtl/input_vc_ctrl_if.sv
// Link and router-side signals of one mesh-router input port.
// master = router top / upstream link, slave = input_vc_ctrl.
interface input_vc_ctrl_if #(
    parameter int unsigned DW = 64
);
    logic          polarity;
    logic          send_in;
    logic          ready_in;
    logic [DW-1:0] data_in;
    logic [4:0]    req;
    logic [DW-1:0] data_out;
    logic [4:0]    clear;
    // One-cycle diagnostic pulses: wrong VC bit on an accepted packet, non-one-hot clear
    logic          vc_error;
    logic          clear_error;

    modport master (
        output polarity, send_in, data_in, clear,
        input  ready_in, req, data_out, vc_error, clear_error
    );

    modport slave (
        input  polarity, send_in, data_in, clear,
        output ready_in, req, data_out, vc_error, clear_error
    );
endinterface

// File: rtl/input_vc_ctrl.sv
// Input-port controller: two VC buffers (even/odd), XY route precomputed at write,
// one-hot request toward the five output controllers for the VC matching polarity.
module input_vc_ctrl #(
    parameter int unsigned DW = 64
) (
    input  logic            clk,
    input  logic            reset,
    input_vc_ctrl_if.slave  bus
);
    localparam int unsigned NUM_OUT = 5;
    localparam int unsigned VC_BIT  = 63;
    localparam int unsigned XDIR    = 62;
    localparam int unsigned YDIR    = 61;
    localparam int unsigned HX_LO   = 52;
    localparam int unsigned HY_LO   = 48;
    localparam int unsigned HOP_W   = 4;

    localparam logic [NUM_OUT-1:0] ROUTE_PE = 5'b00001;
    localparam logic [NUM_OUT-1:0] ROUTE_S  = 5'b00010;
    localparam logic [NUM_OUT-1:0] ROUTE_N  = 5'b00100;
    localparam logic [NUM_OUT-1:0] ROUTE_E  = 5'b01000;
    localparam logic [NUM_OUT-1:0] ROUTE_W  = 5'b10000;

    logic [1:0]         full;
    logic [DW-1:0]      hdr   [2];
    logic [NUM_OUT-1:0] route [2];
    logic               vc_error_q;
    logic               clear_error_q;

    logic               wr_vc;
    logic               rd_vc;
    logic               wr_en;
    logic               fr_en;
    logic               clear_multi;
    logic [HOP_W-1:0]   hop_x;
    logic [HOP_W-1:0]   hop_y;
    logic [DW-1:0]      new_hdr;
    logic [NUM_OUT-1:0] new_route;

    // The link writes the VC opposite to polarity; the router side reads the matching one
    assign wr_vc       = ~bus.polarity;
    assign rd_vc       = bus.polarity;
    assign wr_en       = bus.send_in & ~full[wr_vc];
    assign fr_en       = full[rd_vc] & (bus.clear != '0);
    assign clear_multi = (bus.clear & (bus.clear - NUM_OUT'(1))) != '0;
    assign hop_x       = bus.data_in[HX_LO +: HOP_W];
    assign hop_y       = bus.data_in[HY_LO +: HOP_W];

    // XY route decode and hop rewrite of the incoming packet
    always_comb begin
        new_hdr   = bus.data_in;
        new_route = ROUTE_PE;
        if (hop_x != '0) begin
            new_hdr[HX_LO +: HOP_W] = hop_x - HOP_W'(1);
            new_route = bus.data_in[XDIR] ? ROUTE_W : ROUTE_E;
        end else if (hop_y != '0) begin
            new_hdr[HY_LO +: HOP_W] = hop_y - HOP_W'(1);
            new_route = bus.data_in[YDIR] ? ROUTE_S : ROUTE_N;
        end
        new_hdr[VC_BIT] = wr_vc;
    end

    // Buffer state: write and free always target different VCs on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            full          <= '0;
            hdr[0]        <= '0;
            hdr[1]        <= '0;
            route[0]      <= '0;
            route[1]      <= '0;
            vc_error_q    <= 1'b0;
            clear_error_q <= 1'b0;
        end else begin
            if (wr_en) begin
                full[wr_vc]  <= 1'b1;
                hdr[wr_vc]   <= new_hdr;
                route[wr_vc] <= new_route;
            end
            if (fr_en) begin
                full[rd_vc] <= 1'b0;
            end
            vc_error_q    <= wr_en & (bus.data_in[VC_BIT] != wr_vc);
            clear_error_q <= fr_en & clear_multi;
        end
    end

    // Outputs depend only on registers and polarity, never on clear or send_in
    assign bus.ready_in    = ~full[wr_vc];
    assign bus.req         = full[rd_vc] ? route[rd_vc] : '0;
    assign bus.data_out    = full[rd_vc] ? hdr[rd_vc] : '0;
    assign bus.vc_error    = vc_error_q;
    assign bus.clear_error = clear_error_q;
endmodule

// File: tb/tb_input_vc_ctrl.sv
// Directed bench for input_vc_ctrl: XY decode, local delivery, backpressure,
// simultaneous write/free, clear corner cases and mid-operation reset.
module tb_input_vc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    input_vc_ctrl_if #(.DW(64)) bus ();

    input_vc_ctrl #(.DW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Packets (inputs) and their expected stored images
    localparam logic [63:0] P_XY  = 64'h0023_0000_0000_ABCD;
    localparam logic [63:0] E_XY  = 64'h0013_0000_0000_ABCD;
    localparam logic [63:0] P_LOC = 64'h4000_1234_5678_9ABC;
    localparam logic [63:0] E_LOC = 64'hC000_1234_5678_9ABC;
    localparam logic [63:0] P_A   = 64'hA002_0000_0000_00AA;
    localparam logic [63:0] E_A   = 64'hA001_0000_0000_00AA;
    localparam logic [63:0] P_B   = 64'h4030_0000_0000_00BB;
    localparam logic [63:0] E_B   = 64'h4020_0000_0000_00BB;
    localparam logic [63:0] P_C   = 64'h8011_0000_0000_00CC;
    localparam logic [63:0] P_D   = 64'h8001_0000_0000_00DD;
    localparam logic [63:0] E_D   = 64'h8000_0000_0000_00DD;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: polarity flips after the edge, outputs settle before checking
    task automatic tick();
        @(posedge clk);
        #1 bus.polarity = ~bus.polarity;
        #1;
    endtask

    task automatic outs(input string tag, input logic rdy, input logic [4:0] rq, input logic [63:0] d);
        check({tag, ".ready_in"}, 64'(bus.ready_in), 64'(rdy));
        check({tag, ".req"},      64'(bus.req),      64'(rq));
        check({tag, ".data_out"}, bus.data_out,      d);
    endtask

    initial begin
        reset        = 1'b1;
        bus.polarity = 1'b0;
        bus.send_in  = 1'b0;
        bus.data_in  = '0;
        bus.clear    = '0;
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset, both polarities
        for (int i = 0; i < 10; i++) begin
            outs("idle", 1'b1, 5'b00000, 64'h0);
            tick();
        end

        // XY decode: written at polarity 1 into VC0, requested next cycle
        if (bus.polarity != 1'b1) tick();
        bus.send_in = 1'b1;
        bus.data_in = P_XY;
        tick();
        bus.send_in = 1'b0;
        outs("xy", 1'b1, 5'b01000, E_XY);
        check("xy.hops", 64'(bus.data_out[55:48]), 64'h13);
        check("xy.vc_error", 64'(bus.vc_error), 64'h0);
        bus.clear = 5'b01000;
        tick();
        bus.clear = '0;
        outs("xy.freed_p1", 1'b1, 5'b00000, 64'h0);
        tick();
        outs("xy.freed_p0", 1'b1, 5'b00000, 64'h0);

        // Local delivery into VC1 with a wrong VC bit: stored bit 63 forced to 1
        bus.send_in = 1'b1;
        bus.data_in = P_LOC;
        tick();
        bus.send_in = 1'b0;
        outs("local", 1'b1, 5'b00001, E_LOC);
        check("local.vc_error", 64'(bus.vc_error), 64'h1);
        bus.clear = 5'b00001;
        tick();
        bus.clear = '0;
        outs("local.freed", 1'b1, 5'b00000, 64'h0);
        check("local.vc_error_clr", 64'(bus.vc_error), 64'h0);

        // Backpressure: fill VC1 then VC0, keep pushing, never clear
        bus.send_in = 1'b1;
        bus.data_in = P_A;
        tick();
        bus.data_in = P_B;
        tick();
        bus.data_in = P_C;
        for (int i = 0; i < 6; i++) begin
            if (bus.polarity == 1'b0) outs("bp.p0", 1'b0, 5'b10000, E_B);
            else                      outs("bp.p1", 1'b0, 5'b00010, E_A);
            tick();
        end
        bus.send_in = 1'b0;

        // Simultaneous: free VC1 first, then write VC1 while clearing VC0
        tick();
        bus.clear = 5'b00010;
        tick();
        bus.clear = '0;
        outs("sim.pre", 1'b1, 5'b10000, E_B);
        bus.send_in = 1'b1;
        bus.data_in = P_D;
        bus.clear   = 5'b10000;
        tick();
        bus.send_in = 1'b0;
        bus.clear   = '0;
        outs("sim.vc1", 1'b1, 5'b00100, E_D);
        tick();
        outs("sim.vc0", 1'b0, 5'b00000, 64'h0);

        // Clear aimed at an empty VC is ignored
        bus.clear = 5'b00001;
        tick();
        bus.clear = '0;
        outs("clr_empty", 1'b1, 5'b00100, E_D);
        check("clr_empty.err", 64'(bus.clear_error), 64'h0);

        // Non-one-hot clear still frees and flags an error
        bus.clear = 5'b00110;
        tick();
        bus.clear = '0;
        check("clr_multi.err", 64'(bus.clear_error), 64'h1);
        outs("clr_multi.p0", 1'b1, 5'b00000, 64'h0);
        tick();
        outs("clr_multi.p1", 1'b1, 5'b00000, 64'h0);
        check("clr_multi.err_clr", 64'(bus.clear_error), 64'h0);

        // Reset with both VCs full
        bus.send_in = 1'b1;
        bus.data_in = P_B;
        tick();
        bus.data_in = P_A;
        tick();
        bus.send_in = 1'b0;
        outs("rst.full", 1'b0, 5'b00010, E_A);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            outs("rst.after", 1'b1, 5'b00000, 64'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
